// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_pkg
//  Purpose  : Shared state encoding, exception cause codes and vector for the
//             5-stage pipeline stall/flush sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      EXC      = 2'd2
   } state_t;

   // Same encoding as the cause field carried in EX/MEM.
   localparam logic [1:0] CAUSE_NONE   = 2'b00;
   localparam logic [1:0] CAUSE_IRQ    = 2'b01;
   localparam logic [1:0] CAUSE_UNDEF  = 2'b10;
   localparam logic [1:0] CAUSE_BUSERR = 2'b11;

   localparam logic [31:0] EXC_VECTOR = 32'h4000_0010;

   function automatic logic load_use_hit(
      input logic       memrd,
      input logic [4:0] rf,
      input logic [4:0] rs,
      input logic [4:0] rt
   );
      return memrd && (rf != 5'd0) && ((rf == rs) || (rf == rt));
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Purpose  : Pipeline status in / stall-flush controls out for the hazard
//             sequencer. master = CPU datapath side, slave = sequencer side.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if;

   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic       idex_MemRd;
   logic [4:0] idex_Rf;
   logic       id_jump;
   logic       ex_branch_taken;
   logic       id_eret;
   logic       exmem_MemRd;
   logic       exmem_MemWr;
   logic       mem_ready;
   logic       irq;
   logic       id_undef;

   logic       pc_hold;
   logic       ifid_hold;
   logic       ifid_flush;
   logic       idex_flush;
   logic       exmem_hold;
   logic       ex_wr;
   logic [1:0] ex_ano;
   logic       in_kernel;

   modport master (
      output id_rs, id_rt, idex_MemRd, idex_Rf, id_jump, ex_branch_taken,
             id_eret, exmem_MemRd, exmem_MemWr, mem_ready, irq, id_undef,
      input  pc_hold, ifid_hold, ifid_flush, idex_flush, exmem_hold,
             ex_wr, ex_ano, in_kernel
   );

   modport slave (
      input  id_rs, id_rt, idex_MemRd, idex_Rf, id_jump, ex_branch_taken,
             id_eret, exmem_MemRd, exmem_MemWr, mem_ready, irq, id_undef,
      output pc_hold, ifid_hold, ifid_flush, idex_flush, exmem_hold,
             ex_wr, ex_ano, in_kernel
   );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Purpose  : Counts data-memory wait cycles; flags when MEM_TIMEOUT is reached.
//  Revision : 1.0  initial release
// ============================================================================
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic advance,
   input  logic clear,
   output logic expired
);

   logic [TO_W-1:0] count_q;
   logic [TO_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (start) begin
         count_d = TO_W'(1);
      end else if (advance) begin
         count_d = count_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == TO_W'(MEM_TIMEOUT));

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Stall/flush sequencer for the 5-stage pipeline: load-use, branch,
//             jump, memory wait with timeout, exception entry and kernel mask.
//             Optional macro PIPE_PERF_CNT_EN adds stall/flush event counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 5,
   parameter int PERF_W      = 32
) (
   input  logic                clk,
   input  logic                reset,
   pipe_hazard_ctrl_if.slave   bus
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0]   stall_cycles,
   output logic [PERF_W-1:0]   flush_events
`endif
);

   if ((MEM_TIMEOUT < 1) || ((1 << TO_W) <= MEM_TIMEOUT) || (PERF_W < 1)) begin : g_bad_params
      $error("pipe_hazard_ctrl: MEM_TIMEOUT/TO_W/PERF_W out of range");
   end

   state_t     state_q;
   state_t     state_d;
   logic       in_kernel_q;
   logic       in_kernel_d;

   logic       timer_start;
   logic       timer_advance;
   logic       timer_clear;
   logic       timer_expired;

   logic       mem_busy;
   logic       load_use;
   logic [1:0] exc_cause;
   logic       run_decide;
   logic       freeze;
   logic       take;
   logic [1:0] take_cause;

   logic       pc_hold;
   logic       ifid_hold_raw;
   logic       ifid_hold;
   logic       ifid_flush;
   logic       idex_flush;
   logic       exmem_hold;
   logic       ex_wr;
   logic [1:0] ex_ano;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TO_W        (TO_W)
   ) u_mem_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .start   (timer_start),
      .advance (timer_advance),
      .clear   (timer_clear),
      .expired (timer_expired)
   );

   always_comb begin
      mem_busy  = (bus.exmem_MemRd | bus.exmem_MemWr) & ~bus.mem_ready;
      load_use  = load_use_hit(bus.idex_MemRd, bus.idex_Rf, bus.id_rs, bus.id_rt);
      exc_cause = bus.id_undef                 ? CAUSE_UNDEF :
                  (bus.irq & ~in_kernel_q)     ? CAUSE_IRQ   : CAUSE_NONE;
   end

   always_comb begin
      state_d       = RUN;
      in_kernel_d   = in_kernel_q;
      timer_start   = 1'b0;
      timer_advance = 1'b0;
      timer_clear   = 1'b0;
      run_decide    = 1'b0;
      freeze        = 1'b0;
      take          = 1'b0;
      take_cause    = CAUSE_NONE;
      pc_hold       = 1'b0;
      ifid_hold_raw = 1'b0;
      ifid_hold     = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      exmem_hold    = 1'b0;
      ex_wr         = 1'b0;
      ex_ano        = CAUSE_NONE;

      unique case (state_q)
         RUN: begin
            run_decide = 1'b1;
         end
         MEM_WAIT: begin
            if (bus.mem_ready) begin
               // Access done: the pipeline advances this cycle, so decode as in RUN.
               timer_clear = 1'b1;
               run_decide  = 1'b1;
            end else if (timer_expired) begin
               timer_clear = 1'b1;
               take        = 1'b1;
               take_cause  = CAUSE_BUSERR;
            end else begin
               freeze        = 1'b1;
               timer_advance = 1'b1;
               state_d       = MEM_WAIT;
            end
         end
         EXC: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (run_decide) begin
         if (mem_busy) begin
            freeze      = 1'b1;
            timer_start = 1'b1;
            state_d     = MEM_WAIT;
         end else if (exc_cause != CAUSE_NONE) begin
            take       = 1'b1;
            take_cause = exc_cause;
         end else if (bus.ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (bus.id_jump) begin
            ifid_flush = 1'b1;
         end else if (load_use) begin
            pc_hold       = 1'b1;
            ifid_hold_raw = 1'b1;
            idex_flush    = 1'b1;
         end else if (bus.id_eret) begin
            in_kernel_d = 1'b0;
         end
      end

      // ID/EX is frozen through pc_hold gating, so no bubble is injected here.
      if (freeze) begin
         pc_hold       = 1'b1;
         ifid_hold_raw = 1'b1;
         exmem_hold    = 1'b1;
      end

      if (take) begin
         ex_wr       = 1'b1;
         ex_ano      = take_cause;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         in_kernel_d = 1'b1;
         state_d     = EXC;
      end

      ifid_hold = ifid_hold_raw & ~ifid_flush;

      // Outputs are forced quiet for the whole (asynchronous) reset window.
      if (reset) begin
         pc_hold    = 1'b0;
         ifid_hold  = 1'b0;
         ifid_flush = 1'b0;
         idex_flush = 1'b0;
         exmem_hold = 1'b0;
         ex_wr      = 1'b0;
         ex_ano     = CAUSE_NONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         in_kernel_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_kernel_q <= in_kernel_d;
      end
   end

   assign bus.pc_hold    = pc_hold;
   assign bus.ifid_hold  = ifid_hold;
   assign bus.ifid_flush = ifid_flush;
   assign bus.idex_flush = idex_flush;
   assign bus.exmem_hold = exmem_hold;
   assign bus.ex_wr      = ex_wr;
   assign bus.ex_ano     = ex_ano;
   assign bus.in_kernel  = in_kernel_q;

`ifdef PIPE_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cycles_q;
   logic [PERF_W-1:0] stall_cycles_d;
   logic [PERF_W-1:0] flush_events_q;
   logic [PERF_W-1:0] flush_events_d;

   always_comb begin
      stall_cycles_d = stall_cycles_q + PERF_W'(pc_hold);
      flush_events_d = flush_events_q + PERF_W'(ifid_flush);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_events = flush_events_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Scoreboard bench: directed scenarios plus random traffic against a
//             cycle-level behavioural model of the stall/flush sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int TMO = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] flush_events;
`endif

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT (TMO),
      .TO_W        (3),
      .PERF_W      (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef PIPE_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
`endif
   );

   typedef struct packed {
      logic       pc_hold;
      logic       ifid_hold;
      logic       ifid_flush;
      logic       idex_flush;
      logic       exmem_hold;
      logic       ex_wr;
      logic [1:0] ex_ano;
      logic       in_kernel;
   } out_t;

   typedef struct {
      bit [4:0] rs, rt, rf;
      bit memrd, jump, br, eret, exrd, exwr, ready, irq, undef, rst;
   } in_t;

   out_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Model state: cycles spent frozen on memory (0 = not frozen),
   // a pending handler-fetch cycle, and the kernel flag.
   int   m_wait   = 0;
   bit   m_exc    = 0;
   bit   m_kernel = 0;

   function automatic out_t dut_out();
      return {bus.pc_hold, bus.ifid_hold, bus.ifid_flush, bus.idex_flush,
              bus.exmem_hold, bus.ex_wr, bus.ex_ano, bus.in_kernel};
   endfunction

   function automatic in_t idle();
      in_t v;
      v = '{default: 0};
      return v;
   endfunction

   task automatic model(input in_t v, output out_t e);
      bit memop;
      bit lu;
      int cause;
      e = '0;
      if (v.rst) begin
         m_wait = 0; m_exc = 0; m_kernel = 0;
         return;
      end
      e.in_kernel = m_kernel;
      memop = v.exrd || v.exwr;
      lu    = v.memrd && v.rf != 0 && (v.rf == v.rs || v.rf == v.rt);
      if (m_exc) begin
         m_exc = 0;
         return;
      end
      if (m_wait > 0 && !v.ready) begin
         if (m_wait == TMO) begin
            e.ex_wr = 1; e.ex_ano = 2'b11; e.ifid_flush = 1; e.idex_flush = 1;
            m_kernel = 1; m_exc = 1; m_wait = 0;
         end else begin
            e.pc_hold = 1; e.ifid_hold = 1; e.exmem_hold = 1;
            m_wait = m_wait + 1;
         end
         return;
      end
      m_wait = 0;
      if (memop && !v.ready) begin
         e.pc_hold = 1; e.ifid_hold = 1; e.exmem_hold = 1;
         m_wait = 1;
         return;
      end
      cause = v.undef ? 2 : (v.irq && !m_kernel) ? 1 : 0;
      if (cause != 0) begin
         e.ex_wr = 1; e.ex_ano = 2'(cause); e.ifid_flush = 1; e.idex_flush = 1;
         m_kernel = 1; m_exc = 1;
      end else if (v.br) begin
         e.ifid_flush = 1; e.idex_flush = 1;
      end else if (v.jump) begin
         e.ifid_flush = 1;
      end else if (lu) begin
         e.pc_hold = 1; e.ifid_hold = 1; e.idex_flush = 1;
      end else if (v.eret) begin
         m_kernel = 0;
      end
   endtask

   task automatic apply(input in_t v);
      reset               = v.rst;
      bus.id_rs           = v.rs;
      bus.id_rt           = v.rt;
      bus.idex_Rf         = v.rf;
      bus.idex_MemRd      = v.memrd;
      bus.id_jump         = v.jump;
      bus.ex_branch_taken = v.br;
      bus.id_eret         = v.eret;
      bus.exmem_MemRd     = v.exrd;
      bus.exmem_MemWr     = v.exwr;
      bus.mem_ready       = v.ready;
      bus.irq             = v.irq;
      bus.id_undef        = v.undef;
   endtask

   task automatic issue(input in_t v);
      out_t e;
      @(posedge clk);
      #1;
      apply(v);
      model(v, e);
      exp_q.push_back(e);
   endtask

   // Monitor: one expected response per cycle, compared mid-cycle.
   initial begin
      out_t e;
      out_t a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_out();
            cyc = cyc + 1;
            checks = checks + 1;
            if (a !== e) begin
               errors = errors + 1;
               $display("FAIL outputs cyc %0d: got {pch,ifh,iff,idf,emh,exwr,ano,ink}=%b required %b",
                        cyc, a, e);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion, required $finish");
      $fatal(1);
   end

   initial begin
      in_t v;
      apply(idle());
      reset = 1'b1;

      v = idle(); v.rst = 1;
      repeat (2) issue(v);
      issue(idle());

      // Load-use with a real register, then with $zero.
      v = idle(); v.memrd = 1; v.rf = 8; v.rs = 8;
      issue(v);
      issue(idle());
      v = idle(); v.memrd = 1; v.rf = 0; v.rs = 0;
      issue(v);

      // Memory wait for three cycles then ready.
      v = idle(); v.exrd = 1;
      repeat (3) issue(v);
      v.ready = 1;
      issue(v);
      issue(idle());

      // Timeout: never ready -> bus error, EXC, then RUN in kernel.
      v = idle(); v.exwr = 1;
      repeat (TMO + 1) issue(v);
      repeat (2) issue(idle());

      // eret leaves kernel; irq is taken, masked, then retaken after eret.
      v = idle(); v.eret = 1;
      issue(v);
      v = idle(); v.irq = 1;
      repeat (4) issue(v);
      v.eret = 1;
      issue(v);
      v.eret = 0;
      repeat (2) issue(v);
      v = idle(); v.eret = 1;
      issue(v);

      // Branch beats load-use; undef beats irq.
      v = idle(); v.br = 1; v.memrd = 1; v.rf = 5; v.rt = 5;
      issue(v);
      v = idle(); v.undef = 1; v.irq = 1;
      issue(v);
      issue(idle());
      v = idle(); v.eret = 1;
      issue(v);

      // Asynchronous reset in the middle of a memory wait.
      v = idle(); v.exrd = 1;
      repeat (2) issue(v);
      v.rst = 1;
      issue(v);
      #1;
      checks = checks + 1;
      if (dut_out() !== '0) begin
         errors = errors + 1;
         $display("FAIL async_reset: got %b required %b", dut_out(), 9'b0);
      end
      v.rst = 0;
      repeat (TMO + 1) issue(v);
      repeat (2) issue(idle());

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         v        = idle();
         v.rst    = ($urandom_range(0, 199) == 0);
         v.rs     = 5'($urandom_range(0, 3));
         v.rt     = 5'($urandom_range(0, 3));
         v.rf     = 5'($urandom_range(0, 3));
         v.memrd  = ($urandom_range(0, 9) < 3);
         v.jump   = ($urandom_range(0, 9) < 1);
         v.br     = ($urandom_range(0, 9) < 1);
         v.eret   = ($urandom_range(0, 9) < 1);
         v.exrd   = ($urandom_range(0, 9) < 2);
         v.exwr   = ($urandom_range(0, 19) < 1);
         v.ready  = ($urandom_range(0, 9) < 3);
         v.irq    = ($urandom_range(0, 9) < 1);
         v.undef  = ($urandom_range(0, 39) < 1);
         issue(v);
      end

      repeat (2) @(negedge clk);
      #1;
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: got %0d pending responses required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
